// File: rtl/bv2_mul_dom.sv
// Domain-oriented masked GF(2^2) multiplier in normal basis, NUM_SHARES shares.
// One register stage separates the cross-domain terms from integration; OUT_REG adds a second.
module bv2_mul_dom #(
  parameter int unsigned NUM_SHARES = 2,
  parameter bit          OUT_REG    = 1'b0
) (
  input  logic                                      in_clock,
  input  logic                                      in_reset,
  input  logic                                      in_valid,
  input  logic [NUM_SHARES-1:0][1:0]                in_a,
  input  logic [NUM_SHARES-1:0][1:0]                in_b,
  input  logic [NUM_SHARES*(NUM_SHARES-1)-1:0]      in_random,
  output logic [NUM_SHARES-1:0][1:0]                out_c,
  output logic                                      out_valid
);

  typedef logic [1:0] bv2_t;

  if (NUM_SHARES < 2) begin : gen_bad_shares
    $error("bv2_mul_dom: NUM_SHARES must be at least 2");
  end

  function automatic bv2_t gf4_mul(bv2_t x, bv2_t y);
    logic t;
    t = (x[0] ^ x[1]) & (y[0] ^ y[1]);
    return {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};
  endfunction

  // Lexicographic index of share pair (i,j), i<j.
  function automatic int unsigned pair_idx(int unsigned i, int unsigned j);
    return i * NUM_SHARES - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Stage 1: one register per domain term.
  bv2_t inner_d [NUM_SHARES];
  bv2_t inner_q [NUM_SHARES];
  bv2_t cross_d [NUM_SHARES][NUM_SHARES];
  bv2_t cross_q [NUM_SHARES][NUM_SHARES];
  logic valid1_d, valid1_q;

  always_comb begin
    valid1_d = in_valid;
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      inner_d[i] = in_valid ? gf4_mul(in_a[i], in_b[i]) : inner_q[i];
      for (int unsigned j = 0; j < NUM_SHARES; j++) begin
        if (i == j) begin
          cross_d[i][j] = '0;
        end else if (in_valid) begin
          cross_d[i][j] = gf4_mul(in_a[i], in_b[j]) ^
                          in_random[2 * ((i < j) ? pair_idx(i, j) : pair_idx(j, i)) +: 2];
        end else begin
          cross_d[i][j] = cross_q[i][j];
        end
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      valid1_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SHARES; i++) begin
        inner_q[i] <= '0;
        for (int unsigned j = 0; j < NUM_SHARES; j++) begin
          cross_q[i][j] <= '0;
        end
      end
    end else begin
      valid1_q <= valid1_d;
      for (int unsigned i = 0; i < NUM_SHARES; i++) begin
        inner_q[i] <= inner_d[i];
        for (int unsigned j = 0; j < NUM_SHARES; j++) begin
          cross_q[i][j] <= cross_d[i][j];
        end
      end
    end
  end

  // Integration only ever touches registered terms.
  logic [NUM_SHARES-1:0][1:0] sum_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      sum_c[i] = inner_q[i];
      for (int unsigned j = 0; j < NUM_SHARES; j++) begin
        if (i != j) begin
          sum_c[i] = sum_c[i] ^ cross_q[i][j];
        end
      end
    end
  end

  if (OUT_REG) begin : gen_out_reg
    logic [NUM_SHARES-1:0][1:0] out_c_d, out_c_q;
    logic                       out_valid_d, out_valid_q;

    always_comb begin
      out_valid_d = valid1_q;
      out_c_d     = valid1_q ? sum_c : out_c_q;
    end

    always_ff @(posedge in_clock) begin
      if (in_reset) begin
        out_valid_q <= 1'b0;
        out_c_q     <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_c_q     <= out_c_d;
      end
    end

    assign out_c     = out_c_q;
    assign out_valid = out_valid_q;
  end else begin : gen_no_out_reg
    assign out_c     = sum_c;
    assign out_valid = valid1_q;
  end

endmodule

// File: tb/tb_bv2_mul_dom.sv
// Self-checking bench for bv2_mul_dom: three configurations, scoreboard on unmasked products.
module tb_bv2_mul_dom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  c;
    int unsigned due;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t qr[$];

  // u2: 2 shares, latency 1; u3: 3 shares, latency 1; ur: 2 shares, latency 2
  logic            v2, ov2, v3, ov3, vr, ovr;
  logic [1:0][1:0] a2, b2, c2, ar, br, cr;
  logic [2:0][1:0] a3, b3, c3;
  logic [1:0]      r2, rr;
  logic [5:0]      r3;

  bv2_mul_dom #(.NUM_SHARES(2), .OUT_REG(1'b0)) u2 (
    .in_clock(clk), .in_reset(rst), .in_valid(v2), .in_a(a2), .in_b(b2),
    .in_random(r2), .out_c(c2), .out_valid(ov2)
  );

  bv2_mul_dom #(.NUM_SHARES(3), .OUT_REG(1'b0)) u3 (
    .in_clock(clk), .in_reset(rst), .in_valid(v3), .in_a(a3), .in_b(b3),
    .in_random(r3), .out_c(c3), .out_valid(ov3)
  );

  bv2_mul_dom #(.NUM_SHARES(2), .OUT_REG(1'b1)) ur (
    .in_clock(clk), .in_reset(rst), .in_valid(vr), .in_a(ar), .in_b(br),
    .in_random(rr), .out_c(cr), .out_valid(ovr)
  );

  // Reference normal-basis product.
  function automatic logic [1:0] mul(logic [1:0] x, logic [1:0] y);
    logic x2, y2;
    x2 = x[0] ^ x[1];
    y2 = y[0] ^ y[1];
    return {(x[1] & y[1]) ^ (x2 & y2), (x[0] & y[0]) ^ (x2 & y2)};
  endfunction

  function automatic logic [1:0][1:0] split2(logic [1:0] v);
    logic [1:0] m;
    m = 2'($urandom);
    return {m ^ v, m};
  endfunction

  function automatic logic [2:0][1:0] split3(logic [1:0] v);
    logic [1:0] m0, m1;
    m0 = 2'($urandom);
    m1 = 2'($urandom);
    return {v ^ m0 ^ m1, m1, m0};
  endfunction

  function automatic logic [1:0] unmask2(logic [1:0][1:0] s);
    return s[0] ^ s[1];
  endfunction

  function automatic logic [1:0] unmask3(logic [2:0][1:0] s);
    return s[0] ^ s[1] ^ s[2];
  endfunction

  // Scoreboard monitors: pop on out_valid, flag outputs that never show up.
  always @(negedge clk) begin
    exp_t e;
    if (ov2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL u2_unexpected_valid: out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q2.pop_front();
        if (unmask2(c2) !== e.c || cyc != e.due) begin
          errors++;
          $display("FAIL u2_product: c=%0d at cycle %0d, required c=%0d at cycle %0d",
                   unmask2(c2), cyc, e.c, e.due);
        end
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      checks++;
      errors++;
      e = q2.pop_front();
      $display("FAIL u2_missing_valid: out_valid=%b at cycle %0d, required 1", ov2, cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov3 === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_valid: out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q3.pop_front();
        if (unmask3(c3) !== e.c || cyc != e.due) begin
          errors++;
          $display("FAIL u3_product: c=%0d at cycle %0d, required c=%0d at cycle %0d",
                   unmask3(c3), cyc, e.c, e.due);
        end
      end
    end else if (q3.size() > 0 && q3[0].due <= cyc) begin
      checks++;
      errors++;
      e = q3.pop_front();
      $display("FAIL u3_missing_valid: out_valid=%b at cycle %0d, required 1", ov3, cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ovr === 1'b1) begin
      checks++;
      if (qr.size() == 0) begin
        errors++;
        $display("FAIL ur_unexpected_valid: out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = qr.pop_front();
        if (unmask2(cr) !== e.c || cyc != e.due) begin
          errors++;
          $display("FAIL ur_product: c=%0d at cycle %0d, required c=%0d at cycle %0d",
                   unmask2(cr), cyc, e.c, e.due);
        end
      end
    end else if (qr.size() > 0 && qr[0].due <= cyc) begin
      checks++;
      errors++;
      e = qr.pop_front();
      $display("FAIL ur_missing_valid: out_valid=%b at cycle %0d, required 1", ovr, cyc);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_u2_valid: got %b, required 0", ov2); end
    if (c2 !== '0) begin errors++; $display("FAIL reset_u2_c: got %h, required 0", c2); end
    if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_u3_valid: got %b, required 0", ov3); end
    if (c3 !== '0) begin errors++; $display("FAIL reset_u3_c: got %h, required 0", c3); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ur_valid: got %b, required 0", ovr); end
    if (cr !== '0) begin errors++; $display("FAIL reset_ur_c: got %h, required 0", cr); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0][1:0] held;
    @(posedge clk); #1;
    v2 = 1'b1;
    a2 = {2'd0, 2'd1};
    b2 = {2'd0, 2'd2};
    r2 = 2'd0;
    q2.push_back('{c: mul(2'd1, 2'd2), due: cyc + 1});
    @(posedge clk); #1;
    v2 = 1'b0;
    a2 = split2(2'($urandom));
    b2 = split2(2'($urandom));
    r2 = 2'($urandom);
    @(negedge clk);
    held = c2;
    checks++;
    if (ov2 !== 1'b1 || unmask2(c2) !== mul(2'd1, 2'd2)) begin
      errors++;
      $display("FAIL basic_product: valid=%b c=%0d, required valid=1 c=%0d",
               ov2, unmask2(c2), mul(2'd1, 2'd2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ov2 !== 1'b0 || c2 !== held) begin
      errors++;
      $display("FAIL basic_hold: valid=%b c=%h, required valid=0 c=%h", ov2, c2, held);
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        v3 = 1'b1;
        a3 = split3(2'(a));
        b3 = split3(2'(b));
        r3 = 6'($urandom);
        q3.push_back('{c: mul(2'(a), 2'(b)), due: cyc + 1});
      end
    end
    @(posedge clk); #1;
    v3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL exhaustive_drain: %0d outstanding, required 0", q3.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [1:0] a, b;
    pat = 4'b1011;  // applied LSB first: 1,1,0,1
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a = 2'($urandom);
      b = 2'($urandom);
      vr = pat[k];
      ar = split2(a);
      br = split2(b);
      rr = 2'($urandom);
      if (pat[k]) qr.push_back('{c: mul(a, b), due: cyc + 2});
    end
    @(posedge clk); #1;
    vr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (qr.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: %0d outstanding, required 0", qr.size());
    end
  endtask

  task automatic test_random_independence();
    logic [1:0] base0;
    // a = 1^3 = 2, b = 2^1 = 3
    base0 = mul(2'd1, 2'd2) ^ mul(2'd1, 2'd1);
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      v2 = 1'b1;
      a2 = {2'd3, 2'd1};
      b2 = {2'd1, 2'd2};
      r2 = 2'(r);
      q2.push_back('{c: mul(2'd2, 2'd3), due: cyc + 1});
      @(posedge clk); #1;
      v2 = 1'b0;
      @(negedge clk);
      checks++;
      if (c2[0] !== (base0 ^ 2'(r))) begin
        errors++;
        $display("FAIL rand_share0 r=%0d: share0=%0d, required %0d", r, c2[0], base0 ^ 2'(r));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    v2 = 1'b1;
    a2 = split2(2'd3);
    b2 = split2(2'd3);
    r2 = 2'($urandom);
    q2.push_back('{c: mul(2'd3, 2'd3), due: cyc + 1});
    @(posedge clk); #1;
    rst = 1'b1;
    a2 = split2(2'd2);
    b2 = split2(2'd1);
    r2 = 2'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    a2 = split2(2'd1);
    b2 = split2(2'd1);
    r2 = 2'($urandom);
    q2.push_back('{c: mul(2'd1, 2'd1), due: cyc + 1});
    @(negedge clk);
    checks++;
    if (ov2 !== 1'b0 || c2 !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: valid=%b c=%h, required valid=0 c=0", ov2, c2);
    end
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    checks++;
    if (ov2 !== 1'b1 || unmask2(c2) !== mul(2'd1, 2'd1)) begin
      errors++;
      $display("FAIL reset_mid_resume: valid=%b c=%0d, required valid=1 c=%0d",
               ov2, unmask2(c2), mul(2'd1, 2'd1));
    end
  endtask

  task automatic test_hold();
    logic [1:0][1:0] held;
    @(posedge clk); #1;
    v2 = 1'b1;
    a2 = split2(2'd3);
    b2 = split2(2'd2);
    r2 = 2'($urandom);
    q2.push_back('{c: mul(2'd3, 2'd2), due: cyc + 1});
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    held = c2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a2 = split2(2'($urandom));
      b2 = split2(2'($urandom));
      r2 = 2'($urandom);
      @(negedge clk);
      checks++;
      if (ov2 !== 1'b0 || c2 !== held || unmask2(c2) !== mul(2'd3, 2'd2)) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b c=%h, required valid=0 c=%h (unmasked %0d)",
                 k, ov2, c2, held, mul(2'd3, 2'd2));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    v2 = 1'b0; a2 = '0; b2 = '0; r2 = '0;
    v3 = 1'b0; a3 = '0; b3 = '0; r3 = '0;
    vr = 1'b0; ar = '0; br = '0; rr = '0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_back_to_back();
    test_random_independence();
    test_reset_mid();
    test_hold();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q2.size() + q3.size() + qr.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d outstanding, required 0", q2.size() + q3.size() + qr.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
